// File: rtl/pwm_wave_pkg.sv
// Shared types and limits for the multi-channel PWM wave generator.
package pwm_wave_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int NCH_MAX   = 16;

  typedef logic [DEF_WIDTH-1:0]       cnt_t;
  typedef logic [$clog2(NCH_MAX)-1:0] ch_idx_t;

  typedef struct packed {
    cnt_t period;
    cnt_t duty;
  } chan_cfg_t;

endpackage

// File: rtl/pwm_wave_chan.sv
// One PWM channel: period counter, active/pending config and registered output.
// With TC_PULSE_EN defined, also emits a terminal-count pulse aligned to the wave rising edge.
module pwm_wave_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_duty,
`ifdef TC_PULSE_EN
  output logic             tc,
`endif
  output logic             wave
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pend_period;
  logic [WIDTH-1:0] pend_duty;
  logic             pend;
  logic             run;
  logic             wrap;
  logic             boundary;

  // period-1 is only evaluated when period is nonzero, so it never underflows
  always_comb begin
    run      = en && (period != '0);
    wrap     = run && (cnt == (period - WIDTH'(1)));
    boundary = !run || wrap;
  end

  // Config changes land only at a boundary; a write on that same cycle bypasses the pending regs
  always_ff @(posedge clk) begin
    if (rst) begin
      period      <= '0;
      duty        <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend        <= 1'b0;
    end else if (boundary) begin
      if (wr) begin
        period <= wr_period;
        duty   <= wr_duty;
      end else if (pend) begin
        period <= pend_period;
        duty   <= pend_duty;
      end
      pend <= 1'b0;
    end else if (wr) begin
      pend_period <= wr_period;
      pend_duty   <= wr_duty;
      pend        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else begin
      cnt  <= boundary ? '0 : cnt + WIDTH'(1);
      wave <= run && (cnt < duty);
    end
  end

`ifdef TC_PULSE_EN
  logic wrap_d;

  // Delayed by one extra stage so the pulse coincides with wave's rise at cnt==0
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_d <= 1'b0;
      tc     <= 1'b0;
    end else begin
      wrap_d <= wrap;
      tc     <= wrap_d;
    end
  end
`endif

endmodule

// File: rtl/pwm_wave_gen.sv
// Multi-channel programmable PWM generator: write decode and ack here, per-channel logic in pwm_wave_chan.
// Optional feature macro: TC_PULSE_EN adds the per-channel tc_pulse output.
module pwm_wave_gen
  import pwm_wave_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = 4,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_duty,
  output logic             wr_ack,
`ifdef TC_PULSE_EN
  output logic [NCH-1:0]   tc_pulse,
`endif
  output logic [NCH-1:0]   wave_out
);

  ch_idx_t        wr_idx;
  logic           wr_valid;
  logic [NCH-1:0] wr_sel;

  assign wr_idx = ch_idx_t'(wr_ch);

  // Writes addressed past the last channel are dropped and never acknowledged
  always_comb begin
    wr_valid = wr_en && (int'(wr_idx) < NCH);
    wr_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = wr_valid && (int'(wr_idx) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_valid;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pwm_wave_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[g]),
      .wr       (wr_sel[g]),
      .wr_period(wr_period),
      .wr_duty  (wr_duty),
`ifdef TC_PULSE_EN
      .tc       (tc_pulse[g]),
`endif
      .wave     (wave_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Self-checking bench for pwm_wave_gen against a time-based reference model (phase = elapsed cycles mod period).
// NCH=5 so that channel indices 5..7 exercise the out-of-range write path.
module tb_pwm_wave_gen;

  localparam int WIDTH = 8;
  localparam int NCH   = 5;
  localparam int CHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_period;
  logic [WIDTH-1:0] wr_duty;
  logic             wr_ack;
  logic [NCH-1:0]   wave_out;
`ifdef TC_PULSE_EN
  logic [NCH-1:0]   tc_pulse;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_wave_gen #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_period(wr_period),
    .wr_duty  (wr_duty),
    .wr_ack   (wr_ack),
`ifdef TC_PULSE_EN
    .tc_pulse (tc_pulse),
`endif
    .wave_out (wave_out)
  );

  // Reference model: each channel remembers the cycle at which its phase was 0
  int             m_per   [NCH];
  int             m_duty  [NCH];
  int             m_start [NCH];
  int             m_pper  [NCH];
  int             m_pduty [NCH];
  bit             m_pend  [NCH];
  logic [NCH-1:0] m_wave  = '0;
  logic [NCH-1:0] m_wrapd = '0;
  logic [NCH-1:0] m_tc    = '0;
  logic           m_ack   = 1'b0;
  int             cyc     = 0;

  function automatic int m_phase(int c);
    if (m_per[c] == 0) return 0;
    return (cyc - m_start[c]) % m_per[c];
  endfunction

  task automatic tick();
    logic [NCH-1:0] nw;
    logic [NCH-1:0] nwd;
    logic [NCH-1:0] ntc;
    logic           na;
    nw  = '0;
    nwd = '0;
    ntc = '0;
    na  = wr_en && (int'(wr_ch) < NCH);
    for (int c = 0; c < NCH; c++) begin
      int ph;
      bit run;
      bit wrap;
      bit sel;
      ph   = m_phase(c);
      run  = ch_en[c] && (m_per[c] != 0);
      wrap = run && (ph == m_per[c] - 1);
      sel  = wr_en && (int'(wr_ch) == c);
      nw[c]  = run && (ph < m_duty[c]);
      nwd[c] = wrap;
      ntc[c] = m_wrapd[c];
      if (!run) m_start[c] = cyc + 1;
      if (!run || wrap) begin
        if (sel) begin
          m_per[c]   = int'(wr_period);
          m_duty[c]  = int'(wr_duty);
          m_start[c] = cyc + 1;
        end else if (m_pend[c]) begin
          m_per[c]   = m_pper[c];
          m_duty[c]  = m_pduty[c];
          m_start[c] = cyc + 1;
        end
        m_pend[c] = 1'b0;
      end else if (sel) begin
        m_pend[c]  = 1'b1;
        m_pper[c]  = int'(wr_period);
        m_pduty[c] = int'(wr_duty);
      end
    end
    if (rst) begin
      nw  = '0;
      nwd = '0;
      ntc = '0;
      na  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_per[c]   = 0;
        m_duty[c]  = 0;
        m_pend[c]  = 1'b0;
        m_pper[c]  = 0;
        m_pduty[c] = 0;
        m_start[c] = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    m_wave  = nw;
    m_ack   = na;
    m_wrapd = nwd;
    m_tc    = ntc;
  endtask

  task automatic do_write(input int ch, input int p, input int d);
    wr_en     = 1'b1;
    wr_ch     = CHW'(ch);
    wr_period = WIDTH'(p);
    wr_duty   = WIDTH'(d);
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (wave_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_wave got=%b exp=%b", wave_out, {NCH{1'b0}});
    end
    checks++;
    if (wr_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ack got=%b exp=0", wr_ack);
    end
  endtask

  task automatic test_basic();
    int hi;
    ch_en = 5'b00001;
    do_write(0, 10, 5);
    checks++;
    if (wr_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ack_pulse got=%b exp=1", wr_ack);
    end
    tick();
    checks++;
    if (wr_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_single got=%b exp=0", wr_ack);
    end
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hi += int'(wave_out[0]);
      checks++;
      if (wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL basic_wave cyc=%0d got=%b exp=%b", cyc, wave_out, m_wave);
      end
    end
    checks++;
    if (hi != 20) begin
      failures++;
      $display("[TB] FAIL basic_duty high_cycles=%0d exp=20", hi);
    end
  endtask

  task automatic test_midwrite();
    int hi;
    tick();
    tick();
    tick();
    do_write(0, 4, 1);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= 14) hi += int'(wave_out[0]);
      checks++;
      if (wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL midwrite_wave cyc=%0d got=%b exp=%b", cyc, wave_out, m_wave);
      end
    end
    checks++;
    if (hi != 4) begin
      failures++;
      $display("[TB] FAIL midwrite_duty high_cycles=%0d exp=4", hi);
    end
  endtask

  task automatic test_boundaries();
    ch_en = 5'b01111;
    do_write(1, 6, 0);
    do_write(2, 8, 12);
    do_write(3, 0, 5);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL bound_wave cyc=%0d got=%b exp=%b", cyc, wave_out, m_wave);
      end
      checks++;
      if (wave_out[3:1] !== 3'b010) begin
        failures++;
        $display("[TB] FAIL bound_const cyc=%0d got=%b exp=010", cyc, wave_out[3:1]);
      end
    end
  endtask

  task automatic test_wrap_write();
    int n;
    int hi;
    logic exp_seq [6];
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    n = 0;
    while (!(m_per[0] != 0 && m_phase(0) == m_per[0] - 1) && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      failures++;
      $display("[TB] FAIL wrap_wait timeout got=%0d exp<64", n);
    end
    do_write(0, 6, 3);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (wave_out[0] !== exp_seq[i] || wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL wrap_bypass step=%0d got=%b exp0=%b model=%b", i, wave_out, exp_seq[i], m_wave);
      end
    end
    n = 0;
    while (m_phase(0) != 0 && n < 64) begin
      tick();
      n++;
    end
    do_write(0, 9, 9);
    do_write(0, 5, 2);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= 10) hi += int'(wave_out[0]);
      checks++;
      if (wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL last_write_wave cyc=%0d got=%b exp=%b", cyc, wave_out, m_wave);
      end
    end
    checks++;
    if (hi != 8) begin
      failures++;
      $display("[TB] FAIL last_write_duty high_cycles=%0d exp=8", hi);
    end
  endtask

  task automatic test_enable();
    int n;
    n = 0;
    while (m_wave[0] !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    ch_en[0] = 1'b0;
    tick();
    checks++;
    if (wave_out[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL en_drop got=%b exp=0", wave_out[0]);
    end
    ch_en[0] = 1'b1;
    tick();
    checks++;
    if (wave_out[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL en_restart got=%b exp=1", wave_out[0]);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (wave_out !== m_wave) begin
        failures++;
        $display("[TB] FAIL en_wave cyc=%0d got=%b exp=%b", cyc, wave_out, m_wave);
      end
    end
  endtask

  task automatic test_reset_pending();
    int n;
    n = 0;
    while (m_phase(0) != 0 && n < 32) begin
      tick();
      n++;
    end
    do_write(0, 20, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wave_out !== '0 || wr_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_pend_out wave=%b ack=%b exp wave=0 ack=0", wave_out, wr_ack);
    end
    ch_en = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (wave_out !== '0) begin
        failures++;
        $display("[TB] FAIL rst_discard cyc=%0d got=%b exp=0", cyc, wave_out);
      end
    end
    for (int ch = NCH; ch < 8; ch++) begin
      do_write(ch, 7, 3);
      checks++;
      if (wr_ack !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bad_ch_ack ch=%0d got=%b exp=0", ch, wr_ack);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (wave_out !== '0) begin
        failures++;
        $display("[TB] FAIL bad_ch_wave cyc=%0d got=%b exp=0", cyc, wave_out);
      end
    end
  endtask

`ifdef TC_PULSE_EN
  task automatic test_tc_pulse();
    int hi4;
    int hi3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ch_en = 5'b11000;
    do_write(4, 1, 1);
    do_write(3, 4, 1);
    for (int i = 0; i < 6; i++) tick();
    hi4 = 0;
    hi3 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hi4 += int'(tc_pulse[4]);
      hi3 += int'(tc_pulse[3]);
      checks++;
      if (tc_pulse !== m_tc) begin
        failures++;
        $display("[TB] FAIL tc_model cyc=%0d got=%b exp=%b", cyc, tc_pulse, m_tc);
      end
    end
    checks++;
    if (hi4 != 20 || hi3 != 5) begin
      failures++;
      $display("[TB] FAIL tc_count p1=%0d exp=20 p4=%0d exp=5", hi4, hi3);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
      end
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_ch     = CHW'($urandom_range(0, 7));
      wr_period = WIDTH'($urandom_range(0, 12));
      wr_duty   = WIDTH'($urandom_range(0, 14));
      tick();
      checks++;
      if (wave_out !== m_wave || wr_ack !== m_ack) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d wave=%b exp=%b ack=%b exp=%b", cyc, wave_out, m_wave, wr_ack, m_ack);
      end
`ifdef TC_PULSE_EN
      checks++;
      if (tc_pulse !== m_tc) begin
        failures++;
        $display("[TB] FAIL random_tc cyc=%0d got=%b exp=%b", cyc, tc_pulse, m_tc);
      end
`endif
    end
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ch_en     = '0;
    wr_en     = 1'b0;
    wr_ch     = '0;
    wr_period = '0;
    wr_duty   = '0;
    for (int c = 0; c < NCH; c++) begin
      m_per[c]   = 0;
      m_duty[c]  = 0;
      m_start[c] = 0;
      m_pper[c]  = 0;
      m_pduty[c] = 0;
      m_pend[c]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_midwrite();
    test_boundaries();
    test_wrap_write();
    test_enable();
    test_reset_pending();
`ifdef TC_PULSE_EN
    test_tc_pulse();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
